// File: rtl/lru_update.sv
// lru_update: per-set tree-PLRU state store with a one-deep update pipeline.
//
// Each set holds an (a_size-1)-bit tree-PLRU row. Node 0 is the root, and
// node a has children 2a+1 (left) and 2a+2 (right). A node bit of 0 points
// the victim path right, and a node bit of 1 points it left.
//
// An accepted access captures the current row of its set. The updated row
// is written back on the following edge. After reset, and after every
// flush, an INIT sweep zeroes one row per cycle before accesses are
// accepted again.
//
// Optional feature macro: LRU_BYPASS_EN
//   defined   - same-set hazards are resolved by forwarding the pending
//               updated row to both the capture path and the lookup path.
//   undefined - a same-set access stalls for one cycle, and a lookup
//               returns the stored row, which may be one cycle stale.
module lru_update #(
    parameter int a_size = 8,
    parameter int sets   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        acc_valid,
    output logic                        acc_ready,
    input  logic [$clog2(sets)-1:0]     acc_set,
    input  logic [$clog2(a_size)-1:0]   acc_way,
    input  logic [$clog2(sets)-1:0]     lookup_set,
    output logic [a_size-2:0]           lru_bits,
    output logic                        init_busy
);

    localparam int SW = $clog2(sets);
    localparam int WW = $clog2(a_size);
    localparam int NB = a_size - 1;

    localparam logic [SW-1:0] LAST_SET = SW'(sets - 1);
    localparam logic [SW-1:0] ONE_S    = {{(SW-1){1'b0}}, 1'b1};
    localparam logic [WW-1:0] ONE_W    = {{(WW-1){1'b0}}, 1'b1};
    localparam logic [WW-1:0] ZERO_W   = {WW{1'b0}};

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state_r;
    logic [SW-1:0]   cnt_r;
    logic            pend_valid_r;
    logic [SW-1:0]   pend_set_r;
    logic [WW-1:0]   pend_way_r;
    logic [NB-1:0]   pend_row_r;
    logic [NB-1:0]   rows_r [sets];

    logic            hazard_s;
    logic            accept_s;
    logic [NB-1:0]   pend_upd_s;
    logic [NB-1:0]   capture_row_s;
    logic [NB-1:0]   lookup_row_s;

    // Walk the path from the root to a leaf, steered by the way bits taken
    // MSB first. Every node on the path is set to the branch taken.
    // Nodes off the path keep their values.
    function automatic logic [NB-1:0] upd(input logic [NB-1:0] row,
                                          input logic [WW-1:0] way);
        logic [NB-1:0] r;
        logic [WW-1:0] w;
        logic [WW-1:0] a;
        logic          b;
        r = row;
        w = way;
        a = ZERO_W;
        for (int i = 0; i < WW; i++) begin
            b    = w[WW-1];
            r[a] = b;
            a    = (a << 1'b1) + ONE_W + (b ? ONE_W : ZERO_W);
            w    = w << 1'b1;
        end
        return r;
    endfunction

    // Hazard detection, the updated pending row, and the accept handshake.
    always_comb begin
        hazard_s   = pend_valid_r && (pend_set_r == acc_set);
        pend_upd_s = upd(pend_row_r, pend_way_r);
        acc_ready  = 1'b0;
        if ((state_r == ST_RUN) && !flush) begin
`ifdef LRU_BYPASS_EN
            acc_ready = 1'b1;
`else
            if (hazard_s) begin
                acc_ready = 1'b0;
            end else begin
                acc_ready = 1'b1;
            end
`endif
        end else begin
            acc_ready = 1'b0;
        end
        accept_s = acc_valid && acc_ready;
    end

    // Select the row captured for a new access and the row loaded for a lookup.
    always_comb begin
        capture_row_s = rows_r[acc_set];
        lookup_row_s  = rows_r[lookup_set];
`ifdef LRU_BYPASS_EN
        if (hazard_s) begin
            capture_row_s = pend_upd_s;
        end else begin
            capture_row_s = rows_r[acc_set];
        end
        if (pend_valid_r && (pend_set_r == lookup_set)) begin
            lookup_row_s = pend_upd_s;
        end else begin
            lookup_row_s = rows_r[lookup_set];
        end
`endif
    end

    // INIT/RUN sequencing and the sweep counter. A flush restarts the sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_INIT;
            cnt_r   <= {SW{1'b0}};
        end else begin
            case (state_r)
                ST_INIT: begin
                    if (flush) begin
                        cnt_r <= {SW{1'b0}};
                    end else if (cnt_r == LAST_SET) begin
                        state_r <= ST_RUN;
                        cnt_r   <= {SW{1'b0}};
                    end else begin
                        cnt_r <= cnt_r + ONE_S;
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        state_r <= ST_INIT;
                        cnt_r   <= {SW{1'b0}};
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    state_r <= ST_INIT;
                    cnt_r   <= {SW{1'b0}};
                end
            endcase
        end
    end

    // Pending-update stage plus the registered lookup output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_r <= 1'b0;
            pend_set_r   <= {SW{1'b0}};
            pend_way_r   <= {WW{1'b0}};
            pend_row_r   <= {NB{1'b0}};
            lru_bits     <= {NB{1'b0}};
        end else begin
            pend_valid_r <= accept_s;
            if (accept_s) begin
                pend_set_r <= acc_set;
                pend_way_r <= acc_way;
                pend_row_r <= capture_row_s;
            end else begin
                pend_set_r <= pend_set_r;
            end
            lru_bits <= lookup_row_s;
        end
    end

    // Row storage. The pending write-back lands first, then the sweep zeroes its row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < sets; k++) begin
                rows_r[k] <= {NB{1'b0}};
            end
        end else begin
            if (pend_valid_r) begin
                rows_r[pend_set_r] <= pend_upd_s;
            end
            if (state_r == ST_INIT) begin
                rows_r[cnt_r] <= {NB{1'b0}};
            end
        end
    end

    // init_busy mirrors the FSM state.
    assign init_busy = (state_r == ST_INIT);

endmodule

// File: tb/tb_lru_update.sv
// tb_lru_update: directed self-checking bench for lru_update (a_size=8, sets=16).
module tb_lru_update;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       flush      = 1'b0;
    logic       acc_valid  = 1'b0;
    logic       acc_ready;
    logic [3:0] acc_set    = 4'd0;
    logic [2:0] acc_way    = 3'd0;
    logic [3:0] lookup_set = 4'd0;
    logic [6:0] lru_bits;
    logic       init_busy;

    int checks   = 0;
    int failures = 0;

    lru_update #(.a_size(8), .sets(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .acc_valid  (acc_valid),
        .acc_ready  (acc_ready),
        .acc_set    (acc_set),
        .acc_way    (acc_way),
        .lookup_set (lookup_set),
        .lru_bits   (lru_bits),
        .init_busy  (init_busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic count_sweep(output int n);
        n = 0;
        while ((init_busy === 1'b1) && (n < 100)) begin
            step();
            n++;
        end
    endtask

    task automatic read_row(input logic [3:0] s, output logic [6:0] r);
        acc_valid  = 1'b0;
        lookup_set = s;
        step();
        step();
        r = lru_bits;
    endtask

    task automatic do_access(input logic [3:0] s, input logic [2:0] w);
        acc_valid = 1'b1;
        acc_set   = s;
        acc_way   = w;
        step();
        acc_valid = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        logic [6:0] r;
        rst_n = 1'b0;
        #2;
        checks++; if (init_busy !== 1'b1) begin failures++; $display("FAIL rst_init_busy got=%b exp=1", init_busy); end
        checks++; if (acc_ready !== 1'b0) begin failures++; $display("FAIL rst_acc_ready got=%b exp=0", acc_ready); end
        checks++; if (lru_bits !== 7'b0000000) begin failures++; $display("FAIL rst_lru_bits got=%b exp=0000000", lru_bits); end
        step();
        step();
        rst_n = 1'b1;
        count_sweep(n);
        checks++; if (n != 16) begin failures++; $display("FAIL rst_sweep_len got=%0d exp=16", n); end
        checks++; if (acc_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_after got=%b exp=1", acc_ready); end
        for (int s = 0; s < 16; s++) begin
            read_row(4'(s), r);
            checks++; if (r !== 7'b0000000) begin failures++; $display("FAIL rst_row%0d got=%b exp=0000000", s, r); end
        end
    endtask

    task automatic test_single_access();
        logic [6:0] r;
        acc_valid = 1'b1;
        acc_set   = 4'd3;
        acc_way   = 3'd5;
        #1;
        checks++; if (acc_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", acc_ready); end
        step();
        acc_valid  = 1'b0;
        lookup_set = 4'd3;
        step();
        step();
        checks++; if (lru_bits !== 7'b0100001) begin failures++; $display("FAIL single_set3_way5 got=%b exp=0100001", lru_bits); end
        read_row(4'd4, r);
        checks++; if (r !== 7'b0000000) begin failures++; $display("FAIL single_set4_untouched got=%b exp=0000000", r); end
        do_access(4'd3, 3'd0);
        read_row(4'd3, r);
        checks++; if (r !== 7'b0100000) begin failures++; $display("FAIL single_set3_way0 got=%b exp=0100000", r); end
    endtask

    task automatic test_back_to_back();
        logic [6:0] r;
        acc_valid = 1'b1;
        acc_set   = 4'd2;
        acc_way   = 3'd0;
        #1;
        checks++; if (acc_ready !== 1'b1) begin failures++; $display("FAIL b2b_first_ready got=%b exp=1", acc_ready); end
        step();
        acc_way = 3'd7;
        #1;
`ifdef LRU_BYPASS_EN
        checks++; if (acc_ready !== 1'b1) begin failures++; $display("FAIL b2b_second_ready got=%b exp=1", acc_ready); end
        step();
`else
        checks++; if (acc_ready !== 1'b0) begin failures++; $display("FAIL b2b_stall got=%b exp=0", acc_ready); end
        step();
        checks++; if (acc_ready !== 1'b1) begin failures++; $display("FAIL b2b_after_stall got=%b exp=1", acc_ready); end
        step();
`endif
        acc_valid = 1'b0;
        read_row(4'd2, r);
        checks++; if (r !== 7'b1000101) begin failures++; $display("FAIL b2b_set2_row got=%b exp=1000101", r); end
        acc_valid = 1'b1;
        acc_set   = 4'd5;
        acc_way   = 3'd2;
        step();
        acc_set = 4'd6;
        acc_way = 3'd1;
        #1;
        checks++; if (acc_ready !== 1'b1) begin failures++; $display("FAIL b2b_diffset_ready got=%b exp=1", acc_ready); end
        step();
        acc_valid = 1'b0;
        read_row(4'd5, r);
        checks++; if (r !== 7'b0000010) begin failures++; $display("FAIL b2b_set5_row got=%b exp=0000010", r); end
        read_row(4'd6, r);
        checks++; if (r !== 7'b0001000) begin failures++; $display("FAIL b2b_set6_row got=%b exp=0001000", r); end
    endtask

    task automatic test_flush();
        int n;
        logic [6:0] r;
        acc_valid = 1'b1;
        acc_set   = 4'd7;
        acc_way   = 3'd3;
        step();
        acc_set    = 4'd8;
        acc_way    = 3'd4;
        flush      = 1'b1;
        lookup_set = 4'd7;
        #1;
        checks++; if (acc_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b exp=0", acc_ready); end
        step();
        flush     = 1'b0;
        acc_valid = 1'b0;
        step();
        checks++; if (lru_bits !== 7'b0010010) begin failures++; $display("FAIL flush_pending_done got=%b exp=0010010", lru_bits); end
        checks++; if (init_busy !== 1'b1) begin failures++; $display("FAIL flush_busy got=%b exp=1", init_busy); end
        count_sweep(n);
        checks++; if (n != 15) begin failures++; $display("FAIL flush_sweep_len got=%0d exp=15", n); end
        for (int s = 0; s < 16; s++) begin
            read_row(4'(s), r);
            checks++; if (r !== 7'b0000000) begin failures++; $display("FAIL flush_row%0d got=%b exp=0000000", s, r); end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [6:0] r;
        do_access(4'd1, 3'd7);
        read_row(4'd1, r);
        checks++; if (r !== 7'b1000101) begin failures++; $display("FAIL mid_set1_row got=%b exp=1000101", r); end
        acc_valid = 1'b1;
        acc_set   = 4'd10;
        acc_way   = 3'd5;
        step();
        acc_valid = 1'b0;
        acc_set   = 4'd0;
        rst_n     = 1'b0;
        #2;
        checks++; if (lru_bits !== 7'b0000000) begin failures++; $display("FAIL mid_async_lru got=%b exp=0000000", lru_bits); end
        checks++; if (init_busy !== 1'b1) begin failures++; $display("FAIL mid_async_busy got=%b exp=1", init_busy); end
        checks++; if (acc_ready !== 1'b0) begin failures++; $display("FAIL mid_async_ready got=%b exp=0", acc_ready); end
        step();
        rst_n = 1'b1;
        count_sweep(n);
        checks++; if (n != 16) begin failures++; $display("FAIL mid_access_sweep got=%0d exp=16", n); end
        read_row(4'd10, r);
        checks++; if (r !== 7'b0000000) begin failures++; $display("FAIL mid_dropped_access got=%b exp=0000000", r); end
        read_row(4'd1, r);
        checks++; if (r !== 7'b0000000) begin failures++; $display("FAIL mid_set1_cleared got=%b exp=0000000", r); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        step();
        step();
        checks++; if (init_busy !== 1'b1) begin failures++; $display("FAIL mid_sweep_busy got=%b exp=1", init_busy); end
        rst_n = 1'b0;
        #2;
        checks++; if (acc_ready !== 1'b0) begin failures++; $display("FAIL mid_sweep_ready got=%b exp=0", acc_ready); end
        step();
        rst_n = 1'b1;
        count_sweep(n);
        checks++; if (n != 16) begin failures++; $display("FAIL mid_sweep_restart got=%0d exp=16", n); end
    endtask

    initial begin
        test_reset();
        test_single_access();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
